spi_master_ctrl: RTL and testbench

Upstream command-side driver for the SPI slave + single-port RAM subsystem. Takes parallel RAM commands (write-address, write-data, read-address, read-data) on a start/ready handshake and serialises each one into a framed SPI transaction on SS_n/MOSI. For read-data commands it deserialises the 8-bit reply from MISO and returns it with a done pulse. SPI runs on the system clock: one bit per clk cycle, no divided SCK.

---
 rtl/spi_ram_pkg.sv | 27 ++
 rtl/spi_shift_reg.sv | 31 +++
 rtl/spi_master_ctrl.sv | 147 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI command master and its shift register.
package spi_ram_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned CMD_W   = 2;
   localparam int unsigned FRAME_W = CMD_W + DATA_W;
   localparam int unsigned CNT_W   = 4;

   localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
   localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LEAD = 3'd1;
   localparam logic [2:0] ST_TX   = 3'd2;
   localparam logic [2:0] ST_TURN = 3'd3;
   localparam logic [2:0] ST_RX   = 3'd4;
   localparam logic [2:0] ST_END  = 3'd5;
   localparam logic [2:0] ST_GAP  = 3'd6;

   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [DATA_W-1:0] data;
   } frame_t;

endpackage

// File: rtl/spi_shift_reg.sv
// Frame shift register: parallel load / MSB-first serial out, serial in with
// a look-ahead of the received byte as it will stand after the current shift.
module spi_shift_reg
   import spi_ram_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               shift,
   input  logic [FRAME_W-1:0] pdata,
   input  logic               sin,
   output logic               sout,
   output logic [DATA_W-1:0]  rx_byte
);

   logic [FRAME_W-1:0] sr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else if (load) begin
         sr_q <= pdata;
      end else if (shift) begin
         sr_q <= {sr_q[FRAME_W-2:0], sin};
      end
   end

   assign sout    = sr_q[FRAME_W-1];
   assign rx_byte = {sr_q[DATA_W-2:0], sin};

endmodule

// File: rtl/spi_master_ctrl.sv
// Command-side SPI master: frames {cmd,wdata} onto SS_n/MOSI, one bit per clk,
// and collects the 8-bit MISO reply for read-data commands.
module spi_master_ctrl
   import spi_ram_pkg::*;
#(
   parameter int unsigned LEAD_CYCLES = 1,
   parameter int unsigned TURN_CYCLES = 2,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CMD_W-1:0]  cmd,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   logic [2:0]        state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic [CMD_W-1:0]  cmd_q, cmd_nxt;
   logic              load_c, shift_c, last_c, sout;
   logic              ready_nxt, done_nxt, ss_n_nxt, mosi_nxt;
   logic [DATA_W-1:0] rx_byte;
   frame_t            frame_c;

   assign frame_c = '{cmd: cmd, data: wdata};
   assign last_c  = (cnt_q == '0);

   spi_shift_reg u_shift (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_c),
      .shift   (shift_c),
      .pdata   (frame_c),
      .sin     (MISO),
      .sout    (sout),
      .rx_byte (rx_byte)
   );

   // Next state, shared down-counter, and next values of the registered outputs
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      cmd_nxt   = cmd_q;
      load_c    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LEAD;
               cnt_nxt   = CNT_W'(LEAD_CYCLES - 1);
               cmd_nxt   = cmd;
               load_c    = 1'b1;
            end
         end
         ST_LEAD: begin
            if (last_c) begin
               state_nxt = ST_TX;
               cnt_nxt   = CNT_W'(FRAME_W - 1);
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         ST_TX: begin
            if (!last_c) begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end else if (cmd_q == CMD_RD_DATA) begin
               state_nxt = ST_TURN;
               cnt_nxt   = CNT_W'(TURN_CYCLES - 1);
            end else begin
               state_nxt = ST_END;
            end
         end
         ST_TURN: begin
            if (last_c) begin
               state_nxt = ST_RX;
               cnt_nxt   = CNT_W'(DATA_W - 1);
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         ST_RX: begin
            if (last_c) begin
               state_nxt = ST_END;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         ST_END: begin
            state_nxt = ST_GAP;
            cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
         end
         ST_GAP: begin
            // ready is already high on the last gap cycle, so a start here is taken
            if (!last_c) begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end else if (start) begin
               state_nxt = ST_LEAD;
               cnt_nxt   = CNT_W'(LEAD_CYCLES - 1);
               cmd_nxt   = cmd;
               load_c    = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      shift_c   = (state_nxt == ST_TX) || (state_q == ST_RX);
      ready_nxt = (state_nxt == ST_IDLE) || ((state_nxt == ST_GAP) && (cnt_nxt == '0));
      ss_n_nxt  = (state_nxt == ST_IDLE) || (state_nxt == ST_GAP);
      mosi_nxt  = (state_nxt == ST_TX) ? sout : 1'b0;
      done_nxt  = (state_nxt == ST_END);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cmd_q   <= '0;
         ready   <= 1'b1;
         done    <= 1'b0;
         rdata   <= '0;
         SS_n    <= 1'b1;
         MOSI    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         cmd_q   <= cmd_nxt;
         ready   <= ready_nxt;
         done    <= done_nxt;
         SS_n    <= ss_n_nxt;
         MOSI    <= mosi_nxt;
         if ((state_q == ST_RX) && last_c) begin
            rdata <= rx_byte;
         end
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl against a bench-side SPI slave/RAM model.
module tb_spi_master_ctrl;

   localparam int LA = 1, TA = 2, GA = 1;
   localparam int LB = 3, TB = 4, GB = 2;

   logic       clk, rst_n;
   logic       start, ready, done, ss_n, mosi, miso;
   logic [1:0] cmd;
   logic [7:0] wdata, rdata;
   logic       start_b, ready_b, done_b, ss_n_b, mosi_b, miso_b;
   logic [1:0] cmd_b;
   logic [7:0] wdata_b, rdata_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] ram [256];
   logic [7:0] m_waddr = '0, m_raddr = '0, m_rdata = '0;

   typedef struct {
      logic [1:0] c;
      logic [7:0] d;
      int         len;
      logic [7:0] rd;
   } vec_t;
   vec_t tbl [10];

   spi_master_ctrl #(.LEAD_CYCLES(LA), .TURN_CYCLES(TA), .GAP_CYCLES(GA)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .wdata(wdata),
      .ready(ready), .done(done), .rdata(rdata), .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
   );

   spi_master_ctrl #(.LEAD_CYCLES(LB), .TURN_CYCLES(TB), .GAP_CYCLES(GB)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .cmd(cmd_b), .wdata(wdata_b),
      .ready(ready_b), .done(done_b), .rdata(rdata_b), .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(miso_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One full command on DUT A; the slave model supplies MISO and tracks RAM effects.
   task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input int exp_len,
                         input logic [7:0] exp_rd);
      int         wait_cyc = 0;
      int         low = 0, done_cnt = 0, done_at = -1, rx0 = LA + 10 + TA;
      logic [9:0] fr = {c, d};
      logic [9:0] mo = '0;
      logic [7:0] mb = ram[m_raddr];
      logic       mosi_bad = 1'b0, rdy_bad = 1'b0;
      logic [7:0] rd_at_done = '0;
      while (!ready && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      chk("ready_timeout", 32'(wait_cyc < 100), 32'd1);
      start = 1'b1; cmd = c; wdata = d;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (ss_n) break;
         if (low >= LA && low < LA + 10) mo[9 - (low - LA)] = mosi;
         else if (mosi) mosi_bad = 1'b1;
         if (ready) rdy_bad = 1'b1;
         if (done) begin
            done_cnt++;
            done_at    = low;
            rd_at_done = rdata;
         end
         miso = (c == 2'b11 && low >= rx0 && low < rx0 + 8) ? mb[7 - (low - rx0)] : 1'b0;
         low++;
         @(negedge clk);
      end
      miso = 1'b0;
      chk("frame_len", 32'(low), 32'(exp_len));
      chk("mosi_stream", 32'(mo), 32'(fr));
      chk("mosi_idle_zero", 32'(mosi_bad), 32'd0);
      chk("ready_low_in_frame", 32'(rdy_bad), 32'd0);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_position", 32'(done_at), 32'(exp_len - 1));
      chk("rdata_at_done", 32'(rd_at_done), 32'(exp_rd));
      chk("rdata_after", 32'(rdata), 32'(exp_rd));
      case (c)
         2'b00:   m_waddr = d;
         2'b01:   ram[m_waddr] = d;
         2'b10:   m_raddr = d;
         default: m_rdata = mb;
      endcase
   endtask

   initial begin
      int lo, hi, frames, gaps_bad, rdy_bad, first_mosi, h;
      logic prev_ss, seen;
      logic [7:0] rd_b, rbyte;

      for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
      tbl[0] = '{2'b00, 8'hA5, 12, 8'h00};
      tbl[1] = '{2'b00, 8'h3C, 12, 8'h00};
      tbl[2] = '{2'b01, 8'h5A, 12, 8'h00};
      tbl[3] = '{2'b10, 8'h3C, 12, 8'h00};
      tbl[4] = '{2'b11, 8'h00, 22, 8'h5A};
      tbl[5] = '{2'b00, 8'h10, 12, 8'h5A};
      tbl[6] = '{2'b01, 8'hC3, 12, 8'h5A};
      tbl[7] = '{2'b10, 8'h10, 12, 8'h5A};
      tbl[8] = '{2'b11, 8'hFF, 22, 8'hC3};
      tbl[9] = '{2'b00, 8'hA5, 12, 8'hC3};

      rst_n = 1'b0; start = 1'b1; cmd = 2'b11; wdata = 8'h00; miso = 1'b0;
      start_b = 1'b0; cmd_b = 2'b00; wdata_b = 8'h00; miso_b = 1'b0;

      // Reset with start held high: start must be ignored
      repeat (3) @(negedge clk);
      chk("rst_ss_n", 32'(ss_n), 32'd1);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      rst_n = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("idle_ss_n", 32'(ss_n), 32'd1);

      for (int i = 0; i < 10; i++) do_cmd(tbl[i].c, tbl[i].d, tbl[i].len, tbl[i].rd);

      // start held high across three commands
      start = 1'b1; cmd = 2'b00; wdata = 8'h81;
      frames = 0; gaps_bad = 0; rdy_bad = 0; hi = 0; prev_ss = 1'b1; seen = 1'b0;
      for (int k = 0; k < 200 && frames < 3; k++) begin
         @(negedge clk);
         if (!ss_n) begin
            if (prev_ss && seen && hi != GA) gaps_bad++;
            if (ready) rdy_bad++;
            hi = 0;
            seen = 1'b1;
            if (done) begin
               frames++;
               if (frames == 3) start = 1'b0;
            end
         end else begin
            hi++;
         end
         prev_ss = ss_n;
      end
      chk("hs_frames", 32'(frames), 32'd3);
      chk("hs_gap_len", 32'(gaps_bad), 32'd0);
      chk("hs_ready_low", 32'(rdy_bad), 32'd0);
      lo = 0;
      repeat (6) begin
         @(negedge clk);
         if (!ss_n) lo++;
      end
      chk("hs_no_extra_frame", 32'(lo), 32'd0);
      m_waddr = 8'h81;

      // Reset mid-TX aborts the frame and clears rdata
      start = 1'b1; cmd = 2'b00; wdata = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_ss_n", 32'(ss_n), 32'd0);
      chk("pre_rst_mosi", 32'(mosi), 32'd1);
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_ss_n", 32'(ss_n), 32'd1);
         chk("midrst_mosi", 32'(mosi), 32'd0);
         chk("midrst_ready", 32'(ready), 32'd1);
         chk("midrst_done", 32'(done), 32'd0);
         chk("midrst_rdata", 32'(rdata), 32'd0);
      end
      rst_n = 1'b1;
      m_rdata = 8'h00;
      @(negedge clk);

      // Randomised commands against the slave/RAM model
      for (int i = 0; i < 40; i++) begin
         logic [1:0] c;
         logic [7:0] d;
         c = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_cmd(c, d, (c == 2'b11) ? LA + 10 + TA + 9 : LA + 11,
                (c == 2'b11) ? ram[m_raddr] : m_rdata);
      end

      // Second instance: LEAD=3, TURN=4, GAP=2 read-data frame
      rbyte = 8'hC3; rd_b = '0; lo = 0; first_mosi = -1;
      start_b = 1'b1; cmd_b = 2'b11; wdata_b = 8'h00;
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (ss_n_b) break;
         if (mosi_b && first_mosi < 0) first_mosi = k + 1;
         if (done_b) rd_b = rdata_b;
         miso_b = (lo >= LB + 10 + TB && lo < LB + 10 + TB + 8) ? rbyte[7 - (lo - (LB + 10 + TB))] : 1'b0;
         lo++;
         @(negedge clk);
      end
      miso_b = 1'b0;
      chk("b_frame_len", 32'(lo), 32'd26);
      chk("b_first_mosi_cycle", 32'(first_mosi), 32'd4);
      chk("b_rdata", 32'(rd_b), 32'hC3);
      h = 1;
      while (!ready_b && h < 10) begin
         @(negedge clk);
         if (!ss_n_b) h = 100;
         h++;
      end
      chk("b_gap_to_ready", 32'(h), 32'(GB));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
